// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: lap storage sizing, time-field widths and
// moduli, the time record layout and the lap recorder FSM states.
package stopwatch_pkg;

    localparam int MAX_LAPS = 10;
    localparam int N_TIMERS = 2;
    localparam int CNT_W    = $clog2(MAX_LAPS + 1);

    localparam int HR_W  = 8;
    localparam int MIN_W = 8;
    localparam int SEC_W = 8;
    localparam int MS_W  = 10;

    // Widest field; the shared subtract stage works at this width.
    localparam int FIELD_W = MS_W;

    localparam int MS_MOD  = 1000;
    localparam int SEC_MOD = 60;
    localparam int MIN_MOD = 60;

    typedef struct packed {
        logic [HR_W-1:0]  hours;
        logic [MIN_W-1:0] minutes;
        logic [SEC_W-1:0] seconds;
        logic [MS_W-1:0]  millisec;
    } time_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SUB_MS = 3'd1,
        ST_SUB_S  = 3'd2,
        ST_SUB_M  = 3'd3,
        ST_SUB_H  = 3'd4,
        ST_WRITE  = 3'd5
    } lap_state_e;

endpackage

// File: rtl/mixed_radix_sub_stage.sv
// One digit of a mixed-radix subtractor: a - b - borrow_in, wrapped into
// [0, modulus) with a borrow out when the raw result goes negative.
module mixed_radix_sub_stage #(
    parameter int W = 10
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         borrow_i,
    input  logic [W-1:0] modulus_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);

    logic [W:0] raw;

    // One extra bit holds the sign of the raw difference.
    always_comb begin
        raw      = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, borrow_i};
        borrow_o = raw[W];
        diff_o   = raw[W] ? (raw[W-1:0] + modulus_i) : raw[W-1:0];
    end

endmodule

// File: rtl/lap_recorder.sv
// Lap recorder: snapshots the selected timer on a lap press, derives the lap
// delta one time field per cycle, and stores (split, delta) records per timer
// behind a registered, index-addressed read port.
module lap_recorder
    import stopwatch_pkg::*;
(
    input  logic              clk_1kHz,
    input  logic              rst,
    input  logic              lap_btn,
    input  logic              clear,
    input  logic              timer_sel,
    input  logic              running,
    input  logic              countdown,
    input  logic [HR_W-1:0]   cur_hours,
    input  logic [MIN_W-1:0]  cur_minutes,
    input  logic [SEC_W-1:0]  cur_seconds,
    input  logic [MS_W-1:0]   cur_millisec,
    input  logic              rd_timer,
    input  logic [CNT_W-1:0]  rd_index,
    input  logic              rd_delta,
    output logic [HR_W-1:0]   rd_hours,
    output logic [MIN_W-1:0]  rd_minutes,
    output logic [SEC_W-1:0]  rd_seconds,
    output logic [MS_W-1:0]   rd_millisec,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  lap_count0,
    output logic [CNT_W-1:0]  lap_count1,
    output logic              full0,
    output logic              full1,
    output logic              overflow,
    output logic              busy
);

    lap_state_e        state_q, state_d;
    logic              lap_btn_prev_q;
    logic              tgt_q, tgt_d;
    time_rec_t         cap_q, cap_d;
    time_rec_t         prev_q, prev_d;
    time_rec_t         delta_q, delta_d;
    logic              borrow_q, borrow_d;
    logic [CNT_W-1:0]  count_q [N_TIMERS];
    logic              overflow_q;
    logic              rd_valid_q, rd_valid_d;
    time_rec_t         rd_rec_q, rd_rec_d;

    time_rec_t         split_mem [N_TIMERS][MAX_LAPS];
    time_rec_t         delta_mem [N_TIMERS][MAX_LAPS];

    logic [N_TIMERS-1:0] full_vec;
    logic              lap_edge, lap_ok, accept, reject_full, abort, wr_en;
    logic [CNT_W-1:0]  sel_count;
    time_rec_t         prev_snap;

    logic [FIELD_W-1:0] sub_a, sub_b, sub_mod, sub_diff;
    logic               sub_bin, sub_bout;

    // A timer is full once it holds MAX_LAPS records.
    always_comb begin
        for (int t = 0; t < N_TIMERS; t++) begin
            full_vec[t] = (count_q[t] == CNT_W'(MAX_LAPS));
        end
    end

    // Lap qualification: a clear in the same cycle always wins over the lap.
    always_comb begin
        lap_edge    = lap_btn & ~lap_btn_prev_q;
        lap_ok      = lap_edge && (state_q == ST_IDLE) && running && !countdown && !clear;
        accept      = lap_ok && !full_vec[timer_sel];
        reject_full = lap_ok && full_vec[timer_sel];
        abort       = clear && (state_q != ST_IDLE) && (tgt_q == timer_sel);
    end

    // Previous split of the selected timer, or zero for its first lap.
    always_comb begin
        sel_count = count_q[timer_sel];
        prev_snap = '0;
        if (sel_count != '0) begin
            prev_snap = split_mem[timer_sel][sel_count - CNT_W'(1)];
        end
    end

    mixed_radix_sub_stage #(
        .W (FIELD_W)
    ) u_sub_stage (
        .a_i       (sub_a),
        .b_i       (sub_b),
        .borrow_i  (sub_bin),
        .modulus_i (sub_mod),
        .diff_o    (sub_diff),
        .borrow_o  (sub_bout)
    );

    // FSM next state and datapath: one time field is subtracted per state.
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would infer a latch.
    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        cap_d    = cap_q;
        prev_d   = prev_q;
        delta_d  = delta_q;
        borrow_d = borrow_q;
        sub_a    = '0;
        sub_b    = '0;
        sub_bin  = 1'b0;
        sub_mod  = FIELD_W'(SEC_MOD);
        wr_en    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d        = ST_SUB_MS;
                    tgt_d          = timer_sel;
                    cap_d.hours    = cur_hours;
                    cap_d.minutes  = cur_minutes;
                    cap_d.seconds  = cur_seconds;
                    cap_d.millisec = cur_millisec;
                    prev_d         = prev_snap;
                    delta_d        = '0;
                    borrow_d       = 1'b0;
                end
            end
            ST_SUB_MS: begin
                sub_a            = cap_q.millisec;
                sub_b            = prev_q.millisec;
                sub_mod          = FIELD_W'(MS_MOD);
                delta_d.millisec = sub_diff;
                borrow_d         = sub_bout;
                state_d          = ST_SUB_S;
            end
            ST_SUB_S: begin
                sub_a           = FIELD_W'(cap_q.seconds);
                sub_b           = FIELD_W'(prev_q.seconds);
                sub_bin         = borrow_q;
                sub_mod         = FIELD_W'(SEC_MOD);
                delta_d.seconds = SEC_W'(sub_diff);
                borrow_d        = sub_bout;
                state_d         = ST_SUB_M;
            end
            ST_SUB_M: begin
                sub_a           = FIELD_W'(cap_q.minutes);
                sub_b           = FIELD_W'(prev_q.minutes);
                sub_bin         = borrow_q;
                sub_mod         = FIELD_W'(MIN_MOD);
                delta_d.minutes = MIN_W'(sub_diff);
                borrow_d        = sub_bout;
                state_d         = ST_SUB_H;
            end
            ST_SUB_H: begin
                sub_a   = FIELD_W'(cap_q.hours);
                sub_b   = FIELD_W'(prev_q.hours);
                sub_bin = borrow_q;
                // A negative delta (time went backwards) is clamped to zero.
                if (sub_bout) begin
                    delta_d = '0;
                end else begin
                    delta_d.hours = HR_W'(sub_diff);
                end
                state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            wr_en   = 1'b0;
        end
    end

    // Control and datapath registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs, independent of statement order.
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            lap_btn_prev_q <= 1'b0;
            tgt_q          <= 1'b0;
            cap_q          <= '0;
            prev_q         <= '0;
            delta_q        <= '0;
            borrow_q       <= 1'b0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            lap_btn_prev_q <= lap_btn;
            tgt_q          <= tgt_d;
            cap_q          <= cap_d;
            prev_q         <= prev_d;
            delta_q        <= delta_d;
            borrow_q       <= borrow_d;
            overflow_q     <= overflow_q | reject_full;
        end
    end

    // Per-timer record counts: clear takes priority over a completing write.
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            for (int t = 0; t < N_TIMERS; t++) begin
                count_q[t] <= '0;
            end
        end else begin
            for (int t = 0; t < N_TIMERS; t++) begin
                if (clear && (timer_sel == 1'(t))) begin
                    count_q[t] <= '0;
                end else if (wr_en && (tgt_q == 1'(t)) && !full_vec[t]) begin
                    count_q[t] <= count_q[t] + CNT_W'(1);
                end
            end
        end
    end

    // Record storage, written at the slot just past the current count.
    // NOTE: the arrays carry no reset; slots beyond the count are never
    // observable because reads are gated by rd_valid.
    always_ff @(posedge clk_1kHz) begin
        if (wr_en) begin
            split_mem[tgt_q][count_q[tgt_q]] <= cap_q;
            delta_mem[tgt_q][count_q[tgt_q]] <= delta_q;
        end
    end

    // Read port selection: out-of-range slots read back as zero.
    always_comb begin
        rd_valid_d = (rd_index < count_q[rd_timer]);
        rd_rec_d   = '0;
        if (rd_valid_d) begin
            rd_rec_d = rd_delta ? delta_mem[rd_timer][rd_index]
                                : split_mem[rd_timer][rd_index];
        end
    end

    // Registered read port, one cycle of latency.
    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_rec_q   <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_rec_q   <= rd_rec_d;
        end
    end

    assign rd_hours    = rd_rec_q.hours;
    assign rd_minutes  = rd_rec_q.minutes;
    assign rd_seconds  = rd_rec_q.seconds;
    assign rd_millisec = rd_rec_q.millisec;
    assign rd_valid    = rd_valid_q;
    assign lap_count0  = count_q[0];
    assign lap_count1  = count_q[1];
    assign full0       = full_vec[0];
    assign full1       = full_vec[1];
    assign overflow    = overflow_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_lap_recorder.sv
// Self-checking bench for lap_recorder: directed scenarios with constant
// expectations plus a randomized run scored against a millisecond-total model.
module tb_lap_recorder;
    import stopwatch_pkg::*;

    logic       clk_1kHz = 1'b0;
    logic       rst, lap_btn, clear, timer_sel, running, countdown;
    logic [7:0] cur_hours, cur_minutes, cur_seconds;
    logic [9:0] cur_millisec;
    logic       rd_timer, rd_delta;
    logic [3:0] rd_index;
    logic [7:0] rd_hours, rd_minutes, rd_seconds;
    logic [9:0] rd_millisec;
    logic       rd_valid, full0, full1, overflow, busy;
    logic [3:0] lap_count0, lap_count1;

    always #5 clk_1kHz = ~clk_1kHz;

    lap_recorder dut (
        .clk_1kHz     (clk_1kHz),
        .rst          (rst),
        .lap_btn      (lap_btn),
        .clear        (clear),
        .timer_sel    (timer_sel),
        .running      (running),
        .countdown    (countdown),
        .cur_hours    (cur_hours),
        .cur_minutes  (cur_minutes),
        .cur_seconds  (cur_seconds),
        .cur_millisec (cur_millisec),
        .rd_timer     (rd_timer),
        .rd_index     (rd_index),
        .rd_delta     (rd_delta),
        .rd_hours     (rd_hours),
        .rd_minutes   (rd_minutes),
        .rd_seconds   (rd_seconds),
        .rd_millisec  (rd_millisec),
        .rd_valid     (rd_valid),
        .lap_count0   (lap_count0),
        .lap_count1   (lap_count1),
        .full0        (full0),
        .full1        (full1),
        .overflow     (overflow),
        .busy         (busy)
    );

    int checks = 0;
    int errors = 0;

    logic [33:0] rd_bus;
    logic [11:0] status_bus;
    assign rd_bus     = {rd_hours, rd_minutes, rd_seconds, rd_millisec};
    assign status_bus = {busy, lap_count0, lap_count1, full0, full1, overflow};

    // Reference model: times are plain millisecond totals.
    int          cur_tot;
    int          m_split [2][MAX_LAPS];
    int          m_delta [2][MAX_LAPS];
    int          m_cnt [2];
    int          m_busy;
    int          m_tgt, m_cap, m_dl;
    bit          m_ovf, m_prev_btn;
    bit          exp_rd_valid;
    logic [33:0] exp_rd;

    function automatic logic [33:0] pack_time(int t);
        return {8'(t / 3600000), 8'((t / 60000) % 60), 8'((t / 1000) % 60), 10'(t % 1000)};
    endfunction

    function automatic logic [11:0] exp_status();
        return {m_busy > 0, 4'(m_cnt[0]), 4'(m_cnt[1]),
                m_cnt[0] == MAX_LAPS, m_cnt[1] == MAX_LAPS, m_ovf};
    endfunction

    task automatic set_time(int t);
        cur_tot      = t;
        cur_hours    = 8'(t / 3600000);
        cur_minutes  = 8'((t / 60000) % 60);
        cur_seconds  = 8'((t / 1000) % 60);
        cur_millisec = 10'(t % 1000);
    endtask

    // Advance the model by the cycle whose inputs are currently driven.
    task automatic model_step();
        bit edge_s;
        int p;
        if (rst) begin
            m_cnt[0] = 0; m_cnt[1] = 0; m_busy = 0; m_ovf = 0; m_prev_btn = 0;
            exp_rd_valid = 0; exp_rd = '0;
            return;
        end
        edge_s = lap_btn && !m_prev_btn;
        if (int'(rd_index) < m_cnt[rd_timer]) begin
            exp_rd_valid = 1;
            exp_rd = pack_time(rd_delta ? m_delta[rd_timer][rd_index] : m_split[rd_timer][rd_index]);
        end else begin
            exp_rd_valid = 0;
            exp_rd = '0;
        end
        if (m_busy > 0) begin
            if (clear && m_tgt == int'(timer_sel)) begin
                m_busy = 0;
            end else begin
                m_busy--;
                if (m_busy == 0) begin
                    m_split[m_tgt][m_cnt[m_tgt]] = m_cap;
                    m_delta[m_tgt][m_cnt[m_tgt]] = m_dl;
                    m_cnt[m_tgt]++;
                end
            end
        end else if (edge_s && running && !countdown && !clear) begin
            if (m_cnt[timer_sel] == MAX_LAPS) begin
                m_ovf = 1;
            end else begin
                m_tgt  = int'(timer_sel);
                m_cap  = cur_tot;
                p      = (m_cnt[m_tgt] == 0) ? 0 : m_split[m_tgt][m_cnt[m_tgt] - 1];
                m_dl   = (m_cap > p) ? m_cap - p : 0;
                m_busy = 5;
            end
        end
        if (clear) m_cnt[timer_sel] = 0;
        m_prev_btn = lap_btn;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_1kHz);
        #1;
    endtask

    task automatic press_lap(logic tmr, int t);
        timer_sel = tmr; set_time(t); running = 1'b1; countdown = 1'b0;
        lap_btn = 1'b1;
        tick();
        lap_btn = 1'b0;
        repeat (6) tick();
    endtask

    task automatic read_slot(logic tmr, int idx, logic dl);
        rd_timer = tmr; rd_index = 4'(idx); rd_delta = dl;
        tick();
    endtask

    task automatic pulse_clear(logic tmr);
        timer_sel = tmr; clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        checks++;
        if (status_bus !== 12'h000) begin
            errors++; $display("FAIL reset_status got %h want 000", status_bus);
        end
        checks++;
        if ({rd_valid, rd_bus} !== 35'h0) begin
            errors++; $display("FAIL reset_read got %h want 0", {rd_valid, rd_bus});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic_laps();
        press_lap(1'b0, 12345);
        press_lap(1'b0, 65100);
        checks++;
        if (lap_count0 !== 4'd2) begin
            errors++; $display("FAIL basic_count got %0d want 2", lap_count0);
        end
        read_slot(1'b0, 0, 1'b0);
        checks++;
        if ({rd_valid, rd_bus} !== {1'b1, 8'd0, 8'd0, 8'd12, 10'd345}) begin
            errors++; $display("FAIL basic_split0 got %h", {rd_valid, rd_bus});
        end
        read_slot(1'b0, 0, 1'b1);
        checks++;
        if ({rd_valid, rd_bus} !== {1'b1, 8'd0, 8'd0, 8'd12, 10'd345}) begin
            errors++; $display("FAIL basic_delta0 got %h", {rd_valid, rd_bus});
        end
        read_slot(1'b0, 1, 1'b0);
        checks++;
        if ({rd_valid, rd_bus} !== {1'b1, 8'd0, 8'd1, 8'd5, 10'd100}) begin
            errors++; $display("FAIL basic_split1 got %h", {rd_valid, rd_bus});
        end
        read_slot(1'b0, 1, 1'b1);
        checks++;
        if ({rd_valid, rd_bus} !== {1'b1, 8'd0, 8'd0, 8'd52, 10'd755}) begin
            errors++; $display("FAIL basic_delta1 got %h", {rd_valid, rd_bus});
        end
    endtask

    task automatic test_borrow_chain();
        pulse_clear(1'b0);
        press_lap(1'b0, 3599999);
        press_lap(1'b0, 3600000);
        read_slot(1'b0, 1, 1'b1);
        checks++;
        if ({rd_valid, rd_bus} !== {1'b1, 8'd0, 8'd0, 8'd0, 10'd1}) begin
            errors++; $display("FAIL borrow_delta got %h want 1 ms", {rd_valid, rd_bus});
        end
    endtask

    task automatic test_gating();
        timer_sel = 1'b0; set_time(3650000);
        running = 1'b0; lap_btn = 1'b1; tick(); lap_btn = 1'b0;
        repeat (6) tick();
        running = 1'b1; countdown = 1'b1; lap_btn = 1'b1; tick(); lap_btn = 1'b0;
        repeat (6) tick();
        countdown = 1'b0;
        checks++;
        if ({busy, lap_count0} !== {1'b0, 4'd2}) begin
            errors++; $display("FAIL gate_idle got busy=%b count=%0d want 0/2", busy, lap_count0);
        end
        set_time(3700000);
        lap_btn = 1'b1; tick(); lap_btn = 1'b0; tick();
        lap_btn = 1'b1; tick(); lap_btn = 1'b0;
        repeat (6) tick();
        checks++;
        if (lap_count0 !== 4'd3) begin
            errors++; $display("FAIL gate_busy_drop got %0d want 3", lap_count0);
        end
        read_slot(1'b0, 2, 1'b1);
        checks++;
        if ({rd_valid, rd_bus} !== {1'b1, 8'd0, 8'd1, 8'd40, 10'd0}) begin
            errors++; $display("FAIL gate_busy_delta got %h", {rd_valid, rd_bus});
        end
    endtask

    task automatic test_read_invalid();
        read_slot(1'b0, 7, 1'b0);
        checks++;
        if ({rd_valid, rd_bus} !== 35'h0) begin
            errors++; $display("FAIL rd_invalid got %h want 0", {rd_valid, rd_bus});
        end
    endtask

    task automatic test_overflow();
        for (int k = 0; k < 11; k++) press_lap(1'b1, (k + 1) * 1000);
        checks++;
        if ({lap_count1, full1, overflow} !== {4'd10, 1'b1, 1'b1}) begin
            errors++; $display("FAIL ovf_state got cnt=%0d full=%b ovf=%b want 10/1/1", lap_count1, full1, overflow);
        end
        read_slot(1'b1, 9, 1'b0);
        checks++;
        if ({rd_valid, rd_bus} !== {1'b1, 8'd0, 8'd0, 8'd10, 10'd0}) begin
            errors++; $display("FAIL ovf_slot9 got %h", {rd_valid, rd_bus});
        end
        pulse_clear(1'b1);
        checks++;
        if ({lap_count1, full1, overflow} !== {4'd0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL ovf_clear got cnt=%0d full=%b ovf=%b want 0/0/1", lap_count1, full1, overflow);
        end
    endtask

    task automatic test_abort();
        pulse_clear(1'b0);
        set_time(5000); running = 1'b1;
        lap_btn = 1'b1; tick(); lap_btn = 1'b0;
        repeat (2) tick();
        pulse_clear(1'b0);
        checks++;
        if ({busy, lap_count0} !== 5'd0) begin
            errors++; $display("FAIL abort_clear got busy=%b count=%0d want 0/0", busy, lap_count0);
        end
        repeat (6) tick();
        read_slot(1'b0, 0, 1'b0);
        checks++;
        if ({lap_count0, rd_valid} !== 5'd0) begin
            errors++; $display("FAIL abort_clear_nowrite got count=%0d valid=%b", lap_count0, rd_valid);
        end
        lap_btn = 1'b1; tick(); lap_btn = 1'b0;
        tick();
        rst = 1'b1; tick(); rst = 1'b0;
        checks++;
        if (status_bus !== 12'h000) begin
            errors++; $display("FAIL abort_rst got %h want 000", status_bus);
        end
        repeat (6) tick();
        checks++;
        if (lap_count0 !== 4'd0) begin
            errors++; $display("FAIL abort_rst_nowrite got %0d want 0", lap_count0);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            lap_btn   = ($urandom_range(0, 2) == 0);
            running   = ($urandom_range(0, 9) != 0);
            countdown = ($urandom_range(0, 9) == 0);
            timer_sel = 1'($urandom_range(0, 1));
            clear     = ($urandom_range(0, 39) == 0);
            set_time($urandom_range(0, 99) * 3600000 + $urandom_range(0, 59) * 60000 +
                     $urandom_range(0, 59) * 1000 + $urandom_range(0, 999));
            rd_timer  = 1'($urandom_range(0, 1));
            rd_index  = 4'($urandom_range(0, 15));
            rd_delta  = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (status_bus !== exp_status()) begin
                errors++; $display("FAIL rand_status cycle %0d got %h want %h", i, status_bus, exp_status());
            end
            checks++;
            if ({rd_valid, rd_bus} !== {exp_rd_valid, exp_rd}) begin
                errors++; $display("FAIL rand_read cycle %0d got %h want %h", i, {rd_valid, rd_bus}, {exp_rd_valid, exp_rd});
            end
        end
        clear = 1'b0; lap_btn = 1'b0;
    endtask

    initial begin
        rst = 1'b1; lap_btn = 1'b0; clear = 1'b0; timer_sel = 1'b0;
        running = 1'b1; countdown = 1'b0; set_time(0);
        rd_timer = 1'b0; rd_index = 4'd0; rd_delta = 1'b0;
        m_busy = 0; m_tgt = 0; m_cap = 0; m_dl = 0;
        m_cnt[0] = 0; m_cnt[1] = 0; m_ovf = 0; m_prev_btn = 0;
        exp_rd_valid = 0; exp_rd = '0;
        test_reset();
        test_basic_laps();
        test_borrow_chain();
        test_gating();
        test_read_invalid();
        test_overflow();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lap_recorder.md
Name: lap_recorder

Overview:
- Lap-split storage stage between the stopwatch timing logic and the multi-view display driver.
- On a lap press it snapshots the running time of the selected timer and computes the lap delta with a sequential mixed-radix subtractor.
- Stores up to MAX_LAPS (split, delta) records per timer, and serves one record to the display through an indexed, registered read port.

Parameters:
- MAX_LAPS, 10, records per timer (count width is 4 bits).
- N_TIMERS, 2, independent timers; timer id is 1 bit.

Ports:
- clk_1kHz  in  1  sole clock, millisecond tick domain
- rst  in  1  synchronous active-high reset
- lap_btn  in  1  debounced lap button, level
- clear  in  1  one-cycle pulse; clears the records of timer `timer_sel`
- timer_sel  in  1  timer whose time is presented and recorded
- running  in  1  selected timer is counting
- countdown  in  1  countdown mode active
- cur_hours  in  8  live hours, 0-99
- cur_minutes  in  8  live minutes, 0-59
- cur_seconds  in  8  live seconds, 0-59
- cur_millisec  in  10  live milliseconds, 0-999
- rd_timer  in  1  timer to read
- rd_index  in  4  lap slot to read
- rd_delta  in  1  read field select: 0 = split, 1 = lap delta
- rd_hours  out  8  read hours
- rd_minutes  out  8  read minutes
- rd_seconds  out  8  read seconds
- rd_millisec  out  10  read milliseconds
- rd_valid  out  1  rd_index < lap_count of rd_timer
- lap_count0  out  4  records held for timer 0
- lap_count1  out  4  records held for timer 1
- full0  out  1  timer 0 has MAX_LAPS records
- full1  out  1  timer 1 has MAX_LAPS records
- overflow  out  1  sticky; a lap was rejected because the target timer was full
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (synchronous): all outputs are 0, both counts are 0, the FSM is IDLE and the edge register is 0. Storage contents need no reset, but reads are gated by rd_valid.
- Lap edge: lap_btn is 1 while lap_btn_prev is 0.
  - Accepted only if FSM is IDLE, running is 1, countdown is 0, and the target timer is not full.
  - Edges arriving while busy are dropped, not queued. The edge register still updates.
  - An edge rejected only because the target is full sets overflow. overflow clears only on rst.
- FSM: IDLE -> SUB_MS -> SUB_S -> SUB_M -> SUB_H -> WRITE -> IDLE, one cycle per state.
  - On accept, in the same cycle:
    - latch timer_sel as tgt;
    - snapshot all cur_* fields into cap;
    - load prev = split at slot count-1 of tgt, or all zeros when count = 0.
  - SUB_MS: d = cap_ms - prev_ms. If d < 0, add 1000 and set borrow.
  - SUB_S / SUB_M: d = cap - prev - borrow. If d < 0, add 60 and set borrow, else clear borrow.
  - SUB_H: d = cap_h - prev_h - borrow. If d < 0, clamp the whole delta to 0.
  - WRITE: store split = cap and the delta at slot count of tgt, then increment count of tgt.
  - Timing: edge sampled at cycle N; the record and the new count are visible at N+6. busy is high for cycles N+1..N+5.
- clear:
  - Sets the count of timer_sel to 0.
  - If the FSM is busy and tgt equals timer_sel, the in-flight record is aborted: FSM returns to IDLE and nothing is written.
  - clear and an accepted lap edge in the same cycle: clear wins and the lap is dropped.
- Read port: registered, 1-cycle latency. If rd_index >= count of rd_timer, rd_valid is 0 and all rd_* data outputs are 0.
- full0 / full1 are combinational from the counts. count saturates at MAX_LAPS and never wraps.

Decomposition:
- Shared package stopwatch_pkg holds:
  - MAX_LAPS and N_TIMERS;
  - field widths (HR_W=8, MIN_W=8, SEC_W=8, MS_W=10);
  - field moduli (1000, 60);
  - the time record struct {hours, minutes, seconds, millisec};
  - the FSM state enum.
- One sub-module, mixed_radix_sub_stage: a combinational single-field subtract with borrow-in, modulus and borrow-out, reused across the SUB_* states.

Test Plan:
- Timer 0 running: lap at 00:00:12.345, then lap at 00:01:05.100 -> slot0 split = delta = 00:00:12.345; slot1 split 00:01:05.100, delta 00:00:52.755; lap_count0 = 2.
- Borrow chain: prev 00:59:59.999, cap 01:00:00.000 -> delta 00:00:00.001.
- 11 laps on timer 1 -> lap_count1 = 10, full1 = 1, overflow = 1, slot 9 unchanged; a following clear with timer_sel = 1 -> count 0, overflow still 1.
- Lap edge with running = 0, or with countdown = 1, or during busy -> no count change, no write.
- Read rd_timer = 0, rd_index = 7 with lap_count0 = 3 -> next cycle rd_valid = 0 and all rd_* = 0.
- clear at N+3 for tgt, and rst at N+2 of a lap -> no record written, count 0, busy low next cycle.
